// File: rtl/halfband_dec_p.sv
// halfband_dec_p: multichannel halfband decimate-by-2 FIR with one shared history RAM and one MAC per channel.
// Define HALFBAND_DEC_ROUND_EN for round-half-up and saturation on the output (adds one cycle of latency).
module halfband_dec_p #(
  parameter int NCH = 8,
  parameter int DW = 24,
  parameter int CW = 18,
  parameter int K = 7,
  parameter int AW = 5,
  parameter int SHIFT = 18
) (
  input  logic                   c,
  input  logic                   reset_n,
  input  logic [NCH*DW-1:0]      id,
  input  logic                   iv,
  input  logic                   cwe,
  input  logic [$clog2(K+1)-1:0] cwa,
  input  logic [CW-1:0]          cwd,
  output logic [NCH*DW-1:0]      od,
  output logic                   ov,
  output logic                   busy,
  output logic                   err
);
  localparam int CAW = $clog2(K+1);
  localparam int NW = $clog2(2*K+1);
  localparam int AC = DW+CW+NW;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  logic [0:0] state;
  logic phase, trig, dv;
  logic [AW-1:0] wa, base, addr, ra, two_cnt;
  logic [NW-1:0] cnt;
  logic [CAW-1:0] ci, ca;
  logic [NCH*DW-1:0] ram [2**AW];
  logic [NCH*DW-1:0] rd, nxt;
  logic [CW-1:0] coef [K+1];
  logic [CW-1:0] cr;
  logic v0, f0, l0, v1, f1, l1, v2, f2, l2, d3, d4, d5;
  assign busy = state == RUN;
  assign trig = iv && !phase && !busy;
  assign two_cnt = AW'({cnt, 1'b0});
  // Newest taps first, then the centre tap, then the mirrored (oldest) taps
  assign addr = cnt < NW'(K) ? base - two_cnt : cnt == NW'(K) ? base - AW'(2*K-1) : base + AW'(2) - two_cnt;
  assign ci = cnt < NW'(K) ? CAW'(cnt) : cnt == NW'(K) ? CAW'(K) : CAW'(NW'(2*K) - cnt);
  always_ff @(posedge c) begin
    if (iv) begin
      ram[wa] <= id;
      wa <= wa + 1'b1;
    end
    if (cwe && !busy && !trig && int'(cwa) <= K) coef[cwa] <= cwd;
    rd <= ram[ra];
    cr <= coef[ca];
  end
  always_ff @(posedge c) begin
    ra <= addr;
    ca <= ci;
    f0 <= cnt == '0;
    l0 <= cnt == NW'(2*K);
    {f1, l1, f2, l2} <= {f0, l0, f1, l1};
    if (!reset_n) begin
      state <= IDLE;
      phase <= 1'b0;
      err <= 1'b0;
      ov <= 1'b0;
      {v0, v1, v2, d3, d4, d5} <= '0;
    end else begin
      if (iv) phase <= !phase;
      if (iv && !phase && busy) err <= 1'b1;
      if (trig) begin
        state <= RUN;
        base <= wa;
        cnt <= '0;
      end else if (busy) begin
        cnt <= cnt + 1'b1;
        if (cnt == NW'(2*K)) state <= IDLE;
      end
      {v0, v1, v2} <= {busy, v0, v1};
      d3 <= v2 && l2;
      d4 <= d3;
      d5 <= d4;
      ov <= dv;
    end
    if (reset_n && dv) od <= nxt;
  end
`ifdef HALFBAND_DEC_ROUND_EN
  logic d6;
  assign dv = d6;
  always_ff @(posedge c) d6 <= reset_n && d5;
`else
  assign dv = d5;
`endif
  for (genvar i = 0; i < NCH; i++) begin : ch
    logic signed [DW+CW-1:0] prod;
    logic signed [AC-1:0] acc, res;
    logic signed [DW-1:0] sh;
    always_ff @(posedge c) begin
      prod <= $signed(rd[i*DW +: DW]) * $signed(cr);
      if (d3) res <= acc;
      if (!reset_n) acc <= '0;
      else if (v2) acc <= f2 ? AC'(prod) : acc + AC'(prod);
    end
`ifdef HALFBAND_DEC_ROUND_EN
    localparam logic signed [AC:0] HALF = (AC+1)'(1) << (SHIFT-1);
    localparam logic signed [AC:0] SMAX = (AC+1)'({(DW-1){1'b1}});
    localparam logic signed [AC:0] SMIN = ~SMAX;
    logic signed [AC:0] rs;
    always_ff @(posedge c) begin
      if (d4) rs <= ((AC+1)'(res) + HALF) >>> SHIFT;
      if (d5) sh <= rs > SMAX ? DW'(SMAX) : rs < SMIN ? DW'(SMIN) : DW'(rs);
    end
`else
    always_ff @(posedge c) if (d4) sh <= DW'(res >>> SHIFT);
`endif
    assign nxt[i*DW +: DW] = sh;
  end
endmodule

// File: tb/tb_halfband_dec_p.sv
// tb_halfband_dec_p: randomized bench for halfband_dec_p against a direct-form convolution model over the full sample history.
module tb_halfband_dec_p;
  localparam int NCH = 8, DW = 24, CW = 18, K = 7, AW = 5, SHIFT = 18;
  localparam int CAW = $clog2(K+1);
`ifdef HALFBAND_DEC_ROUND_EN
  localparam int LAT = 2*K+8;
  localparam longint MAXV = (longint'(1) <<< (DW-1)) - 1;
`else
  localparam int LAT = 2*K+7;
`endif
  logic c = 1'b1;
  logic reset_n = 1'b0;
  logic [NCH*DW-1:0] id = '0;
  logic iv = 1'b0, cwe = 1'b0;
  logic [CAW-1:0] cwa = '0;
  logic [CW-1:0] cwd = '0;
  logic [NCH*DW-1:0] od;
  logic ov, busy, err;
  halfband_dec_p #(.NCH(NCH), .DW(DW), .CW(CW), .K(K), .AW(AW), .SHIFT(SHIFT)) dut (
    .c(c), .reset_n(reset_n), .id(id), .iv(iv), .cwe(cwe), .cwa(cwa), .cwd(cwd),
    .od(od), .ov(ov), .busy(busy), .err(err)
  );
  always #5 c = ~c;
  typedef struct {int cy; logic [NCH*DW-1:0] y; bit known;} exp_t;
  exp_t q[$];
  logic [NCH*DW-1:0] hist[$];
  longint h[K+1];
  longint hv[K+1] = '{44, -264, 1073, -3357, 8856, -22204, 81391, 131069};
  int ne = 0, n_run = 0, n_fail = 0, t0 = -1000;
  bit m_phase = 0, m_err = 0;
  task automatic chk(input string tag, input logic [NCH*DW-1:0] got, input logic [NCH*DW-1:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %h want %h", tag, ne, got, exp);
    end
  endtask
  function automatic longint smp(input int idx, input int ch);
    logic [NCH*DW-1:0] w;
    logic signed [DW-1:0] s;
    w = idx >= 0 ? hist[idx] : '0;
    s = w[ch*DW +: DW];
    return longint'(s);
  endfunction
  // Full 4K-1 tap convolution straight from the halfband equation
  function automatic logic [NCH*DW-1:0] model_y();
    logic [NCH*DW-1:0] r;
    longint acc, v;
    int n;
    r = '0;
    n = hist.size() - 1;
    for (int ch = 0; ch < NCH; ch++) begin
      acc = 0;
      for (int k = 0; k < K; k++) acc += h[k] * (smp(n-2*k, ch) + smp(n-(4*K-2)+2*k, ch));
      acc += h[K] * smp(n-(2*K-1), ch);
`ifdef HALFBAND_DEC_ROUND_EN
      v = (acc + (longint'(1) <<< (SHIFT-1))) >>> SHIFT;
      if (v > MAXV) v = MAXV;
      else if (v < -MAXV-1) v = -MAXV-1;
`else
      v = acc >>> SHIFT;
`endif
      r[ch*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction
  task automatic drive(input bit rn, input bit v, input logic [NCH*DW-1:0] d, input bit we, input int a, input longint wd);
    int e;
    bit bz, tp;
    exp_t x;
    logic signed [CW-1:0] cs;
    @(negedge c);
    reset_n = rn; iv = v; id = d; cwe = we; cwa = CAW'(a); cwd = CW'(wd);
    e = ne + 1;
    if (!rn) begin
      while (q.size() > 0 && q[$].cy >= e) void'(q.pop_back());
      m_phase = 0; m_err = 0; t0 = -1000;
    end else begin
      bz = (e > t0) && (e <= t0 + 2*K + 1);
      tp = v && !m_phase;
      if (v) begin
        hist.push_back(d);
        m_phase = !m_phase;
      end
      if (tp && bz) m_err = 1;
      if (tp && !bz) begin
        t0 = e;
        x.cy = e + LAT; x.y = model_y(); x.known = hist.size() >= 4*K-1;
        q.push_back(x);
      end
      if (we && !bz && !(tp && !bz) && a >= 0 && a <= K) begin
        cs = CW'(wd);
        h[a] = longint'(cs);
      end
    end
    @(posedge c);
    ne++;
  endtask
  task automatic idle(input int n);
    repeat (n) drive(1, 0, '0, 0, 0, 0);
  endtask
  task automatic send(input logic [NCH*DW-1:0] d, input int gap);
    drive(1, 1, d, 0, 0, 0);
    idle(gap - 1);
  endtask
  task automatic wr(input int a, input longint v);
    drive(1, 0, '0, 1, a, v);
  endtask
  function automatic logic [NCH*DW-1:0] dc(input int v);
    logic [NCH*DW-1:0] r;
    for (int ch = 0; ch < NCH; ch++) r[ch*DW +: DW] = DW'(v);
    return r;
  endfunction
  function automatic logic [NCH*DW-1:0] rnd();
    logic [NCH*DW-1:0] r;
    for (int ch = 0; ch < NCH; ch++) r[ch*DW +: DW] = DW'($urandom);
    return r;
  endfunction
  always @(posedge c) begin
    #1;
    if (ne > 0) begin
      chk("busy", busy, (ne >= t0 && ne <= t0 + 2*K));
      chk("err", err, m_err);
      while (q.size() > 0 && q[0].cy < ne) void'(q.pop_front());
      if (q.size() > 0 && q[0].cy == ne) begin
        chk("ov", ov, 1);
        if (q[0].known) chk("od", od, q[0].y);
        void'(q.pop_front());
      end else chk("ov_idle", ov, 0);
    end
  end
  initial begin
    logic [NCH*DW-1:0] imp;
    imp = '0;
    imp[DW-1:0] = DW'(262144);
    repeat (3) drive(0, 0, '0, 0, 0, 0);
    for (int k = 0; k <= K; k++) wr(k, hv[k]);
    repeat (40) send(dc(1000), 12);
    // centre-tap write while busy must be dropped, then the same write while idle lands
    if (m_phase) send(dc(1000), 12);
    drive(1, 1, dc(1000), 0, 0, 0);
    wr(K, 0);
    idle(10);
    repeat (6) send(dc(1000), 12);
    idle(20);
    wr(K, 0);
    repeat (6) send(dc(1000), 12);
    idle(20);
    wr(K, hv[K]);
    repeat (30) send('0, 4);
    if (m_phase) send('0, 4);
    send(imp, 4);
    repeat (20) send('0, 4);
    if (!m_phase) send('0, 4);
    send(imp, 4);
    repeat (20) send('0, 4);
    repeat (80) begin
      drive(1, 1, rnd(), $urandom_range(0, 3) == 0, $urandom_range(0, K), longint'($urandom));
      idle($urandom_range(2, 9));
    end
    idle(20);
    for (int k = 0; k <= K; k++) wr(k, hv[k]);
    if (m_phase) send(dc(1000), 12);
    drive(1, 1, dc(1000), 0, 0, 0);
    idle(4);
    drive(0, 0, '0, 0, 0, 0);
    idle(3);
    repeat (20) send(dc(1000), 12);
    idle(20);
    wr(K, 131071);
    repeat (20) send(dc(8388607), 12);
    idle(20);
    wr(K, hv[K]);
    repeat (20) send(rnd(), 3);
    idle(20);
    drive(0, 0, '0, 0, 0, 0);
    idle(2);
    repeat (6) send(dc(1000), 12);
    idle(40);
    chk("drain", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
